// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data SRAM port arbiter.
// Optional build macro used by the arbiter files: ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   localparam int MEM_LAT  = 1;
   localparam int STARVE_W = 4;

   // Saturating increment used by the fetch starvation counter.
   function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] val,
                                                   input logic [STARVE_W-1:0] lim);
      sat_inc = (val >= lim) ? lim : val + 1'b1;
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and data requesters plus the arbitration history registers.
// Build macro ARB_ROUND_ROBIN_EN selects round-robin; default is data priority with a fetch starvation guard.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIM = 4
) (
   input  logic CLK,
   input  logic RST,
   input  logic IREQ,
   input  logic DREQ,
   output logic IGNT,
   output logic DGNT
);

   logic i_win;
   logic d_win;

`ifdef ARB_ROUND_ROBIN_EN
   owner_t last_gnt;

   // On contention the side that did not win most recently gets the port.
   always_comb begin
      i_win = 1'b0;
      d_win = 1'b0;
      if (!RST) begin
         if (IREQ && DREQ) begin
            if (last_gnt == OWN_D) begin
               i_win = 1'b1;
            end else begin
               d_win = 1'b1;
            end
         end else begin
            i_win = IREQ;
            d_win = DREQ;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         last_gnt <= OWN_I;
      end else if (i_win) begin
         last_gnt <= OWN_I;
      end else if (d_win) begin
         last_gnt <= OWN_D;
      end
   end
`else
   localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIM);

   logic [STARVE_W-1:0] starve_cnt;

   // Data normally wins contention; a fetch denied LIM cycles in a row is forced through.
   always_comb begin
      i_win = 1'b0;
      d_win = 1'b0;
      if (!RST) begin
         if (IREQ && DREQ) begin
            if (starve_cnt == LIM) begin
               i_win = 1'b1;
            end else begin
               d_win = 1'b1;
            end
         end else begin
            i_win = IREQ;
            d_win = DREQ;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         starve_cnt <= '0;
      end else if (!IREQ || i_win) begin
         starve_cnt <= '0;
      end else begin
         starve_cnt <= sat_inc(starve_cnt, LIM);
      end
   end
`endif

   assign IGNT = i_win;
   assign DGNT = d_win;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         assert (!(i_win && d_win)) else $error("mem_arb_prio: double grant");
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between fetch and data ports, one access per cycle, 1-cycle response.
// Build macro ARB_ROUND_ROBIN_EN switches contention handling to round-robin.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW         = 30,
   parameter int DW         = 32,
   parameter int STARVE_LIM = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          IREQ,
   input  logic [AW-1:0] IADDR,
   output logic          IGNT,
   output logic          IVALID,
   output logic [DW-1:0] IRDATA,
   input  logic          DREQ,
   input  logic          DRW,
   input  logic [AW-1:0] DADDR,
   input  logic [DW-1:0] DWDATA,
   output logic          DGNT,
   output logic          DVALID,
   output logic [DW-1:0] DRDATA,
   output logic          MREQ,
   output logic          MRW,
   output logic [AW-1:0] MADDR,
   output logic [DW-1:0] MWDATA,
   input  logic [DW-1:0] MRDATA
);

   // Handshake: a requester raises REQ with stable ADDR/DATA and holds them until GNT is
   // seen high in the same cycle; that cycle is the transfer. Exactly one cycle later the
   // matching VALID pulses for one cycle. Dropping REQ before GNT cancels the request.

   owner_t owner_q;
   logic   wr_q;

   mem_arb_prio #(
      .STARVE_LIM (STARVE_LIM)
   ) u_prio (
      .CLK  (CLK),
      .RST  (RST),
      .IREQ (IREQ),
      .DREQ (DREQ),
      .IGNT (IGNT),
      .DGNT (DGNT)
   );

   assign MREQ   = IGNT | DGNT;
   assign MRW    = DRW & DGNT;
   assign MADDR  = DGNT ? DADDR : IADDR;
   assign MWDATA = DGNT ? DWDATA : '0;

   // The owner register remembers who gets the SRAM output on the following cycle.
   always_ff @(posedge CLK) begin
      if (RST) begin
         owner_q <= OWN_NONE;
         wr_q    <= 1'b0;
      end else begin
         if (IGNT) begin
            owner_q <= OWN_I;
         end else if (DGNT) begin
            owner_q <= OWN_D;
         end else begin
            owner_q <= OWN_NONE;
         end
         wr_q <= DGNT & DRW;
      end
   end

   // RST gates the responses so an access in flight at reset never surfaces.
   assign IVALID = !RST && (owner_q == OWN_I);
   assign DVALID = !RST && (owner_q == OWN_D);
   assign IRDATA = IVALID ? MRDATA : '0;
   assign DRDATA = (DVALID && !wr_q) ? MRDATA : '0;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         assert (!(IVALID && DVALID)) else $error("mem_port_arbiter: double valid");
         assert (MEM_LAT == 1) else $error("mem_port_arbiter: unsupported SRAM latency");
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a rule-level reference model.
// Honours ARB_ROUND_ROBIN_EN when the RTL is built with it.
module tb_mem_port_arbiter;

   localparam int AW         = 30;
   localparam int DW         = 32;
   localparam int STARVE_LIM = 4;

   logic          CLK = 1'b0;
   logic          rst, ireq, dreq, drw;
   logic [AW-1:0] iaddr, daddr;
   logic [DW-1:0] dwdata;
   logic          IGNT, IVALID, DGNT, DVALID, MREQ, MRW;
   logic [DW-1:0] IRDATA, DRDATA, MWDATA;
   logic [DW-1:0] MRDATA = '0;
   logic [AW-1:0] MADDR;

   logic [DW-1:0] sram    [0:255];
   logic [DW-1:0] ref_mem [0:255];
   logic [33:0]   exp_q[$];

   int            n_checks = 0;
   int            n_fail   = 0;
   int            m_denied = 0;
   logic          m_last_d = 1'b0;
   logic          obs_ignt, obs_dgnt, obs_mreq, obs_ivalid, obs_dvalid;
   logic [DW-1:0] obs_irdata, obs_drdata;

   always #5 CLK = ~CLK;

   mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIM(STARVE_LIM)) dut (
      .CLK(CLK), .RST(rst),
      .IREQ(ireq), .IADDR(iaddr), .IGNT(IGNT), .IVALID(IVALID), .IRDATA(IRDATA),
      .DREQ(dreq), .DRW(drw), .DADDR(daddr), .DWDATA(dwdata),
      .DGNT(DGNT), .DVALID(DVALID), .DRDATA(DRDATA),
      .MREQ(MREQ), .MRW(MRW), .MADDR(MADDR), .MWDATA(MWDATA), .MRDATA(MRDATA)
   );

   // Synchronous SRAM: read data appears the cycle after the access.
   always @(posedge CLK) begin
      if (MREQ) begin
         if (MRW) sram[MADDR[7:0]] <= MWDATA;
         else     MRDATA <= sram[MADDR[7:0]];
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs against the model at the falling edge, then advance.
   task automatic cycle();
      logic [33:0] pend;
      logic [1:0]  who;
      logic        e_i, e_d;
      @(negedge CLK);
      obs_ignt = IGNT;  obs_dgnt = DGNT;  obs_mreq = MREQ;
      obs_ivalid = IVALID; obs_dvalid = DVALID;
      obs_irdata = IRDATA; obs_drdata = DRDATA;
      e_i = 1'b0;
      e_d = 1'b0;
      if (!rst) begin
         if (ireq && dreq) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (m_last_d) e_i = 1'b1; else e_d = 1'b1;
`else
            if (m_denied >= STARVE_LIM) e_i = 1'b1; else e_d = 1'b1;
`endif
         end else begin
            e_i = ireq;
            e_d = dreq;
         end
      end
      check_eq("ignt", IGNT, e_i);
      check_eq("dgnt", DGNT, e_d);
      check_eq("mreq", MREQ, e_i | e_d);
      if (e_i | e_d) check_eq("mrw", MRW, e_d & drw);
      if (e_i) check_eq("maddr_i", MADDR, iaddr);
      if (e_d) check_eq("maddr_d", MADDR, daddr);
      if (e_d && drw) check_eq("mwdata", MWDATA, dwdata);

      pend = exp_q.pop_front();
      if (rst) pend = '0;
      who = pend[33:32];
      check_eq("ivalid", IVALID, who == 2'd1);
      check_eq("dvalid", DVALID, who == 2'd2);
      check_eq("irdata", IRDATA, (who == 2'd1) ? pend[31:0] : 32'h0);
      check_eq("drdata", DRDATA, (who == 2'd2) ? pend[31:0] : 32'h0);

      if (e_i) begin
         exp_q.push_back({2'd1, ref_mem[iaddr[7:0]]});
      end else if (e_d && drw) begin
         exp_q.push_back({2'd2, 32'h0});
         ref_mem[daddr[7:0]] = dwdata;
      end else if (e_d) begin
         exp_q.push_back({2'd2, ref_mem[daddr[7:0]]});
      end else begin
         exp_q.push_back(34'h0);
      end

      if (rst || !ireq || e_i) m_denied = 0;
      else if (m_denied < STARVE_LIM) m_denied++;
      if (rst || e_i) m_last_d = 1'b0;
      else if (e_d)   m_last_d = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   initial begin
      rst = 1'b1; ireq = 1'b1; dreq = 1'b1; drw = 1'b0;
      iaddr = '0; daddr = '0; dwdata = '0;
      for (int i = 0; i < 256; i++) begin
         sram[i]    = '0;
         ref_mem[i] = '0;
      end
      sram[16]    = 32'hDEADBEEF;
      ref_mem[16] = 32'hDEADBEEF;
      exp_q.push_back(34'h0);
      @(posedge CLK);
      #1;

      // Reset holds off every grant even with both requests up.
      cycle();
      check_eq("rst_ignt", obs_ignt, 1'b0);
      check_eq("rst_dgnt", obs_dgnt, 1'b0);
      check_eq("rst_mreq", obs_mreq, 1'b0);
      rst = 1'b0; ireq = 1'b0; dreq = 1'b0;
      cycle();
      check_eq("post_rst_ivalid", obs_ivalid, 1'b0);
      check_eq("post_rst_dvalid", obs_dvalid, 1'b0);

      // Lone fetch.
      ireq = 1'b1; iaddr = 30'h10;
      cycle();
      check_eq("fetch_ignt", obs_ignt, 1'b1);
      ireq = 1'b0;
      cycle();
      check_eq("fetch_ivalid", obs_ivalid, 1'b1);
      check_eq("fetch_irdata", obs_irdata, 32'hDEADBEEF);

      // Contention: data wins until the fetch has been denied STARVE_LIM cycles.
      ireq = 1'b1; dreq = 1'b1; drw = 1'b0; iaddr = 30'h11; daddr = 30'h12;
      for (int k = 0; k <= STARVE_LIM; k++) begin
         cycle();
`ifndef ARB_ROUND_ROBIN_EN
         check_eq("starve_dgnt", obs_dgnt, k < STARVE_LIM);
         check_eq("starve_ignt", obs_ignt, k == STARVE_LIM);
`endif
      end
      ireq = 1'b0; dreq = 1'b0;
      cycle();

      // Write then read back the same word.
      dreq = 1'b1; drw = 1'b1; daddr = 30'h20; dwdata = 32'h55;
      cycle();
      check_eq("wr_dgnt", obs_dgnt, 1'b1);
      drw = 1'b0;
      cycle();
      check_eq("wr_ack", obs_dvalid, 1'b1);
      check_eq("wr_ack_data", obs_drdata, 32'h0);
      dreq = 1'b0;
      cycle();
      check_eq("rd_dvalid", obs_dvalid, 1'b1);
      check_eq("rd_data", obs_drdata, 32'h55);

      // Reset while a fetch response is in flight.
      ireq = 1'b1; iaddr = 30'h10;
      cycle();
      check_eq("midrst_ignt", obs_ignt, 1'b1);
      ireq = 1'b0; rst = 1'b1;
      cycle();
      check_eq("midrst_ivalid", obs_ivalid, 1'b0);
      check_eq("midrst_irdata", obs_irdata, 32'h0);
      rst = 1'b0;
      cycle();
      check_eq("midrst_after", obs_ivalid, 1'b0);

      // Both held: alternates under round-robin, data-heavy with periodic fetch otherwise.
      ireq = 1'b1; dreq = 1'b1; drw = 1'b0; iaddr = 30'h3; daddr = 30'h4;
      for (int k = 0; k < 8; k++) cycle();
      ireq = 1'b0; dreq = 1'b0;
      cycle();

      // Random traffic; requests mostly held until granted, occasionally withdrawn.
      for (int n = 0; n < 1500; n++) begin
         if (!ireq || obs_ignt) begin
            ireq  = ($urandom_range(0, 99) < 60);
            iaddr = AW'($urandom_range(0, 63));
         end else if ($urandom_range(0, 99) < 5) begin
            ireq = 1'b0;
         end
         if (!dreq || obs_dgnt) begin
            dreq   = ($urandom_range(0, 99) < 65);
            drw    = $urandom_range(0, 1) == 1;
            daddr  = AW'($urandom_range(0, 63));
            dwdata = $urandom;
         end else if ($urandom_range(0, 99) < 5) begin
            dreq = 1'b0;
         end
         rst = ($urandom_range(0, 99) < 2);
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
